// File: rtl/obs_pkg.sv
// Shared definitions for the obstacle/bonus stream generator: code encoding,
// seven-segment patterns (abcdefg), bonus point values, FSM states and the
// LFSR step function.
package obs_pkg;

    localparam int unsigned CODE_W = 4;

    localparam logic [CODE_W-1:0] CODE_BLANK     = 4'hF;
    localparam logic [CODE_W-1:0] CODE_MAX_OBS   = 4'd9;
    localparam logic [CODE_W-1:0] CODE_MAX_BONUS = 4'd12;

    localparam logic [6:0] PAT_0  = 7'b0001111;
    localparam logic [6:0] PAT_1  = 7'b1100011;
    localparam logic [6:0] PAT_2  = 7'b0111000;
    localparam logic [6:0] PAT_3  = 7'b0010011;
    localparam logic [6:0] PAT_4  = 7'b1000001;
    localparam logic [6:0] PAT_5  = 7'b0111111;
    localparam logic [6:0] PAT_6  = 7'b0110110;
    localparam logic [6:0] PAT_7  = 7'b0010101;
    localparam logic [6:0] PAT_8  = 7'b0110001;
    localparam logic [6:0] PAT_9  = 7'b1111110;
    localparam logic [6:0] PAT_10 = 7'b0110000;
    localparam logic [6:0] PAT_11 = 7'b1101101;
    localparam logic [6:0] PAT_12 = 7'b1111001;

    localparam logic [5:0] PTS_10 = 6'd10;
    localparam logic [5:0] PTS_11 = 6'd20;
    localparam logic [5:0] PTS_12 = 6'd30;

    localparam logic [15:0] SEED_FALLBACK = 16'hACE1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FREEZE = 2'd2
    } obs_state_e;

    function automatic logic [5:0] bonus_points(input logic [CODE_W-1:0] code);
        case (code)
            4'd10:   return PTS_10;
            4'd11:   return PTS_11;
            4'd12:   return PTS_12;
            default: return '0;
        endcase
    endfunction

    // Fibonacci LFSR, taps 16,14,13,11, shifting toward the MSB.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/obs_seg_rom.sv
// Registered code -> seven-segment pattern lookup for one display digit.
// Bonus patterns exist only when OBS_BONUS_EN is defined.
module obs_seg_rom
    import obs_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] code_i,
    output logic [6:0]        seg_o
);

    logic [6:0] seg_d;
    logic [6:0] seg_q;

    // Pattern lookup; unknown and blank codes light nothing.
    always_comb begin
        seg_d = '0;
        case (code_i)
            4'd0:    seg_d = PAT_0;
            4'd1:    seg_d = PAT_1;
            4'd2:    seg_d = PAT_2;
            4'd3:    seg_d = PAT_3;
            4'd4:    seg_d = PAT_4;
            4'd5:    seg_d = PAT_5;
            4'd6:    seg_d = PAT_6;
            4'd7:    seg_d = PAT_7;
            4'd8:    seg_d = PAT_8;
            4'd9:    seg_d = PAT_9;
`ifdef OBS_BONUS_EN
            4'd10:   seg_d = PAT_10;
            4'd11:   seg_d = PAT_11;
            4'd12:   seg_d = PAT_12;
`endif
            default: seg_d = '0;
        endcase
    end

    // Output register, one cycle behind the code register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) seg_q <= '0;
        else     seg_q <= seg_d;
    end

    assign seg_o = seg_q;

endmodule

// File: rtl/generador_obstaculos.sv
// Obstacle/bonus stream generator: draws codes from an LFSR, scrolls them
// toward digit 0 at a level-dependent rate and enforces a blank gap after
// every object. Optional bonus codes are enabled by defining OBS_BONUS_EN.
module generador_obstaculos
    import obs_pkg::*;
#(
    parameter int unsigned N_DIG    = 4,
    parameter int unsigned TICK_DIV = 25_000_000,
    parameter int unsigned GAP      = 1,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               freeze,
    input  logic [1:0]         level,
    input  logic               clr_front,
    output logic [7*N_DIG-1:0] seg_bus,
    output logic [3:0]         front_code,
    output logic               step,
    output logic [5:0]         bonus_pts
);

    localparam int unsigned CNT_W    = $clog2(TICK_DIV);
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0) ? SEED_FALLBACK : SEED;
    localparam logic [2:0]  GAP_L    = 3'(GAP);

    obs_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [2:0]        gap_q, gap_d;
    logic [CODE_W-1:0] code_q [N_DIG];
    logic [CODE_W-1:0] code_d [N_DIG];
    logic              step_q, step_d;

    logic [31:0]       per_m1;
    logic [CODE_W-1:0] rnd_code;
    logic [CODE_W-1:0] new_code;
    logic [2:0]        new_gap;

    assign per_m1 = (32'(TICK_DIV) >> level) - 32'd1;

    // Code entering the far digit on the next scroll, and the gap it leaves.
    always_comb begin
        rnd_code = lfsr_q[3:0];
`ifdef OBS_BONUS_EN
        if (rnd_code > CODE_MAX_BONUS) rnd_code = CODE_BLANK;
`else
        if (rnd_code > CODE_MAX_OBS) rnd_code = CODE_BLANK;
`endif
        if (gap_q != '0) begin
            new_code = CODE_BLANK;
            new_gap  = gap_q - 3'd1;
        end else begin
            new_code = rnd_code;
            new_gap  = (rnd_code == CODE_BLANK) ? 3'd0 : GAP_L;
        end
    end

    // FSM, tick counter, row shift and front clear; freeze beats start.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        code_d  = code_q;
        step_d  = 1'b0;
        lfsr_d  = (state_q == ST_RUN) ? lfsr_next(lfsr_q) : lfsr_q;

        if (freeze) begin
            if (state_q == ST_RUN) state_d = ST_FREEZE;
        end else if (start) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            gap_d   = '0;
            for (int unsigned k = 0; k < N_DIG; k++) code_d[k] = CODE_BLANK;
        end else if (state_q == ST_RUN) begin
            // >= rather than == so a level raise past the count steps at once
            if (32'(cnt_q) >= per_m1) begin
                cnt_d  = '0;
                step_d = 1'b1;
                gap_d  = new_gap;
                for (int unsigned k = 0; k < N_DIG - 1; k++) code_d[k] = code_q[k+1];
                code_d[N_DIG-1] = new_code;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                if (clr_front) code_d[0] = CODE_BLANK;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            lfsr_q  <= SEED_EFF;
            gap_q   <= '0;
            step_q  <= 1'b0;
            for (int unsigned k = 0; k < N_DIG; k++) code_q[k] <= CODE_BLANK;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            gap_q   <= gap_d;
            step_q  <= step_d;
            for (int unsigned k = 0; k < N_DIG; k++) code_q[k] <= code_d[k];
        end
    end

    for (genvar g = 0; g < N_DIG; g++) begin : g_rom
        obs_seg_rom u_rom (
            .clk    (clk),
            .rst    (rst),
            .code_i (code_q[g]),
            .seg_o  (seg_bus[7*g +: 7])
        );
    end

    assign front_code = code_q[0];
    assign step       = step_q;

`ifdef OBS_BONUS_EN
    assign bonus_pts = bonus_points(code_q[0]);
`else
    assign bonus_pts = '0;
`endif

endmodule
